// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory: valid/ready fetch port, FETCH_WORDS words per
// response after READ_LATENCY stages, error flag for illegal addresses, flush
// for redirects, and a write-only program port that loads the array.
module instr_mem_pipe #(
    parameter int unsigned IMEM_WORDS   = 1024,
    parameter int unsigned FETCH_WORDS  = 1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [31:0]               req_addr_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [32*FETCH_WORDS-1:0] rsp_data_o,
    output logic                      rsp_err_o,
    input  logic                      flush_i,
    input  logic                      prog_we_i,
    input  logic [31:0]               prog_addr_i,
    input  logic [31:0]               prog_data_i
);

    localparam int unsigned AW = $clog2(IMEM_WORDS);
    localparam int unsigned DW = 32 * FETCH_WORDS;

    logic [31:0]             mem_q [IMEM_WORDS];

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] err_q, err_d;
    logic [DW-1:0]           data_q [READ_LATENCY];
    logic [DW-1:0]           data_d [READ_LATENCY];

    logic          stall;
    logic          accept;
    logic [32:0]   req_end;
    logic          req_err;
    logic [DW-1:0] rd_data;
    logic          prog_in_range;
    logic          unused_prog_lsb;

    // Byte-offset bits of the program address carry no information.
    assign unused_prog_lsb = ^prog_addr_i[1:0];

    assign rsp_valid_o = vld_q[READ_LATENCY-1];
    assign rsp_err_o   = rsp_valid_o && err_q[READ_LATENCY-1];
    assign rsp_data_o  = rsp_valid_o ? data_q[READ_LATENCY-1] : '0;

    assign stall       = rsp_valid_o && !rsp_ready_i;
    assign req_ready_o = !reset && !flush_i && !stall;
    assign accept      = req_valid_i && req_ready_o;

    // End index computed at 33 bits so a fetch near the top of the address
    // space cannot wrap back into range.
    assign req_end = {3'b000, req_addr_i[31:2]} + 33'(FETCH_WORDS);
    assign req_err = (req_addr_i[1:0] != 2'b00) || (req_end > 33'(IMEM_WORDS));

    assign prog_in_range = ({2'b00, prog_addr_i[31:2]} < IMEM_WORDS);

    // Combinational array read of the requested words; illegal fetches read as zero.
    always_comb begin
        rd_data = '0;
        if (!req_err) begin
            for (int unsigned i = 0; i < FETCH_WORDS; i++) begin
                rd_data[32*i +: 32] = mem_q[req_addr_i[AW+1:2] + AW'(i)];
            end
        end
    end

    // Program port write; the read above sees the pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (prog_we_i && !reset && prog_in_range) begin
            mem_q[prog_addr_i[AW+1:2]] <= prog_data_i;
        end
    end

    // Next-state of the pipeline: flush wins, otherwise all stages shift together
    // unless the output is stalled.
    always_comb begin
        vld_d  = vld_q;
        err_d  = err_q;
        data_d = data_q;
        if (flush_i) begin
            vld_d = '0;
        end else if (!stall) begin
            vld_d[0]  = accept;
            err_d[0]  = accept && req_err;
            data_d[0] = accept ? rd_data : '0;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                vld_d[k]  = vld_q[k-1];
                err_d[k]  = err_q[k-1];
                data_d[k] = data_q[k-1];
            end
        end
    end

    // Pipeline stage registers; reset drops every in-flight request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            err_q <= '0;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

endmodule
